raystore_out_fifo: RTL and testbench

- Downstream stage of raystore_simple. Buffers its read results (ray vector plus scoreboard tag) so the next stage, the traversal/intersection consumer, can apply backpressure.
- raystore reads are pipelined, so some reads are already in flight when a stall is raised. This block therefore asserts us_stall early, leaving SLACK free entries to absorb those reads.
- Show-ahead FIFO: the head entry is visible on the ds_* outputs whenever the FIFO is non-empty.

---
 rtl/raystore_out_fifo.sv | 109 ++++++++++
 tb/tb_raystore_out_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/raystore_out_fifo.sv
// raystore_out_fifo: show-ahead output buffer behind raystore_simple.
// It raises us_stall early so SLACK entries stay free for reads already in flight.
// Optional build macro: RAYSTORE_FIFO_OVF_CHECK_EN enables the sticky overflow_err flag
// and a simulation assertion on dropped writes.
module raystore_out_fifo #(
    parameter int unsigned SB_WIDTH  = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned SLACK     = 2,
    parameter type         ray_vec_t = logic [191:0]
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         us_valid,
    input  logic [SB_WIDTH-1:0]          us_sb_data,
    input  logic [$bits(ray_vec_t)-1:0]  us_rd_data,
    output logic                         us_stall,
    output logic                         ds_valid,
    output logic [SB_WIDTH-1:0]          ds_sb_data,
    output logic [$bits(ray_vec_t)-1:0]  ds_rd_data,
    input  logic                         ds_stall,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow_err
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned RdW    = $bits(ray_vec_t);
    localparam int unsigned EntryW = SB_WIDTH + RdW;

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("raystore_out_fifo: DEPTH must be a power of two and at least 4");
    end
    if ((SLACK < 1) || (SLACK >= DEPTH)) begin : g_bad_slack
        $error("raystore_out_fifo: SLACK must satisfy 1 <= SLACK < DEPTH");
    end

    logic [EntryW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              full, pop, push;

    assign full     = (count_q == CntW'(DEPTH));
    assign ds_valid = (count_q != '0);
    assign pop      = ds_valid & ~ds_stall;
    // When full, a simultaneous pop frees the slot being written this edge.
    assign push     = us_valid & (~full | pop);

    // Early backpressure depends on occupancy only, so it carries no input-to-output path.
    assign us_stall = (count_q >= CntW'(DEPTH - SLACK));
    assign count    = count_q;

    // Show-ahead head entry.
    assign {ds_sb_data, ds_rd_data} = mem_q[rd_ptr_q];

    // Occupancy next state.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {us_sb_data, us_rd_data};
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

`ifdef RAYSTORE_FIFO_OVF_CHECK_EN
    logic drop;
    logic ovf_q;

    assign drop         = us_valid & ~push;
    assign overflow_err = ovf_q;

    // Sticky record of any dropped write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_no_drop : assert property (@(posedge clk) disable iff (!rst) !drop)
        else $error("raystore_out_fifo: write dropped while full");
`endif
`else
    assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_raystore_out_fifo.sv
// Self-checking bench for raystore_out_fifo against a queue-based reference model.
module tb_raystore_out_fifo;

    localparam int SbW   = 8;
    localparam int Depth = 8;
    localparam int Slack = 2;
    localparam int RdW   = 192;

    typedef struct packed {
        logic [SbW-1:0] sb;
        logic [RdW-1:0] rd;
    } item_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           us_valid;
    logic [SbW-1:0] us_sb_data;
    logic [RdW-1:0] us_rd_data;
    logic           us_stall;
    logic           ds_valid;
    logic [SbW-1:0] ds_sb_data;
    logic [RdW-1:0] ds_rd_data;
    logic           ds_stall;
    logic [3:0]     count;
    logic           overflow_err;

    raystore_out_fifo #(
        .SB_WIDTH (SbW),
        .DEPTH    (Depth),
        .SLACK    (Slack)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .us_valid     (us_valid),
        .us_sb_data   (us_sb_data),
        .us_rd_data   (us_rd_data),
        .us_stall     (us_stall),
        .ds_valid     (ds_valid),
        .ds_sb_data   (ds_sb_data),
        .ds_rd_data   (ds_rd_data),
        .ds_stall     (ds_stall),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    item_t model[$];
    bit    ovf_m = 1'b0;
    int    drops = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RdW-1:0] rand_rd();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Advance one clock and apply the FIFO rules to the reference queue.
    task automatic tick();
        bit    pop, push;
        item_t in;
        pop  = (model.size() != 0) && !ds_stall;
        push = us_valid && ((model.size() < Depth) || pop);
        in   = '{sb: us_sb_data, rd: us_rd_data};
        @(posedge clk);
        #1;
        if (us_valid && !push) begin
            drops++;
`ifdef RAYSTORE_FIFO_OVF_CHECK_EN
            ovf_m = 1'b1;
`endif
        end
        if (pop)  void'(model.pop_front());
        if (push) model.push_back(in);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".valid"}, ds_valid, model.size() != 0);
        check_eq({tag, ".count"}, count, model.size());
        check_eq({tag, ".us_stall"}, us_stall, model.size() >= Depth - Slack);
        check_eq({tag, ".ovf"}, overflow_err, ovf_m);
        if (model.size() != 0) begin
            check_eq({tag, ".sb"}, ds_sb_data, model[0].sb);
            check_eq({tag, ".rd"}, ds_rd_data, model[0].rd);
        end
    endtask

    task automatic fill_stalled(input logic [SbW-1:0] base);
        ds_stall = 1'b1;
        for (int i = 0; i < Depth; i++) begin
            us_valid   = 1'b1;
            us_sb_data = base + SbW'(i);
            us_rd_data = rand_rd();
            tick();
            check_state("fill");
        end
        us_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        ds_stall = 1'b0;
        us_valid = 1'b0;
        for (int i = 0; i < Depth + 1; i++) begin
            tick();
            check_state(tag);
        end
    endtask

    logic [SbW-1:0] in_log[$];
    logic [SbW-1:0] out_log[$];

    initial begin
        rst        = 1'b0;
        us_valid   = 1'b0;
        us_sb_data = '0;
        us_rd_data = '0;
        ds_stall   = 1'b0;
        #17;
        check_state("reset");
        rst = 1'b1;

        // 1. Single item, one-cycle latency, no fall-through.
        us_valid   = 1'b1;
        us_sb_data = 8'h05;
        us_rd_data = RdW'(16'hA5A5);
        #1;
        check_eq("t1.nofall", ds_valid, 1'b0);
        tick();
        us_valid = 1'b0;
        check_state("t1.head");
        check_eq("t1.sb", ds_sb_data, 8'h05);
        check_eq("t1.rd", ds_rd_data, RdW'(16'hA5A5));
        tick();
        check_eq("t1.empty", ds_valid, 1'b0);
        check_eq("t1.count", count, 4'd0);

        // 2. Fill with consumer stalled, then drain in order.
        ds_stall = 1'b1;
        for (int i = 0; i < Depth; i++) begin
            us_valid   = 1'b1;
            us_sb_data = SbW'(i);
            us_rd_data = rand_rd();
            tick();
            check_state("t2.fill");
            check_eq("t2.stall", us_stall, (i + 1) >= 6);
            check_eq("t2.hold", ds_sb_data, 8'h00);
        end
        us_valid = 1'b0;
        ds_stall = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            check_eq("t2.order", ds_sb_data, SbW'(i));
            tick();
        end
        check_eq("t2.empty", ds_valid, 1'b0);

        // 3. Push and pop together while full.
        fill_stalled(8'h10);
        us_valid   = 1'b1;
        us_sb_data = 8'h20;
        us_rd_data = rand_rd();
        ds_stall   = 1'b0;
        tick();
        us_valid = 1'b0;
        check_eq("t3.count", count, 4'd8);
        check_state("t3.pp");
        for (int i = 0; i < Depth - 1; i++) begin
            tick();
        end
        check_eq("t3.last", ds_sb_data, 8'h20);
        check_state("t3.last");
        tick();
        check_eq("t3.empty", ds_valid, 1'b0);

        // 4. Overflow: write while full and stalled is dropped.
        fill_stalled(8'h28);
        us_valid   = 1'b1;
        us_sb_data = 8'h30;
        us_rd_data = rand_rd();
        ds_stall   = 1'b1;
        tick();
        us_valid = 1'b0;
        check_eq("t4.count", count, 4'd8);
        check_state("t4.ovf");
        drain("t4.drain");
`ifdef RAYSTORE_FIFO_OVF_CHECK_EN
        check_eq("t4.sticky", overflow_err, 1'b1);
`else
        check_eq("t4.sticky", overflow_err, 1'b0);
`endif

        // 5. Asynchronous reset mid-traffic.
        ds_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            us_valid   = 1'b1;
            us_sb_data = 8'h38 + SbW'(i);
            us_rd_data = rand_rd();
            tick();
        end
        us_valid = 1'b0;
        check_eq("t5.pre", count, 4'd5);
        #2 rst = 1'b0;
        #1;
        model.delete();
        ovf_m = 1'b0;
        check_eq("t5.valid", ds_valid, 1'b0);
        check_eq("t5.stall", us_stall, 1'b0);
        check_eq("t5.count", count, 4'd0);
        check_eq("t5.ovf", overflow_err, 1'b0);
        #1 rst = 1'b1;
        us_valid   = 1'b1;
        us_sb_data = 8'h41;
        us_rd_data = rand_rd();
        ds_stall   = 1'b0;
        tick();
        us_valid = 1'b0;
        check_eq("t5.first", ds_sb_data, 8'h41);
        check_state("t5.after");
        tick();
        check_state("t5.empty");

        // 6. Random streaming with us_valid honouring us_stall two cycles late.
        begin
            bit [1:0]       stall_hist;
            bit             lagged;
            logic [SbW-1:0] seq;
            stall_hist = '0;
            seq        = 8'h80;
            drops      = 0;
            for (int c = 0; c < 100; c++) begin
                lagged     = stall_hist[1];
                stall_hist = {stall_hist[0], us_stall};
                us_valid   = ($urandom_range(0, 3) != 0) && !lagged;
                ds_stall   = ($urandom_range(0, 2) == 0);
                us_sb_data = seq;
                us_rd_data = rand_rd();
                if (us_valid) begin
                    in_log.push_back(seq);
                    seq = seq + 8'd1;
                end
                if (ds_valid && !ds_stall) out_log.push_back(ds_sb_data);
                tick();
                check_state("t6.stream");
            end
            us_valid = 1'b0;
            ds_stall = 1'b0;
            for (int c = 0; c < Depth + 2; c++) begin
                if (ds_valid) out_log.push_back(ds_sb_data);
                tick();
            end
            check_eq("t6.drops", drops, 0);
            check_eq("t6.ovf", overflow_err, 1'b0);
            check_eq("t6.len", out_log.size(), in_log.size());
            for (int i = 0; i < in_log.size(); i++) begin
                if (i < out_log.size()) check_eq("t6.seq", out_log[i], in_log[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
